// File: rtl/vga_pkg.sv
// Shared VGA timing constants, alignment payload and helpers.
package vga_pkg;

  // 800x600 @ 72 Hz, 50 MHz pixel clock
  localparam int unsigned SVGA_H_VISIBLE = 800;
  localparam int unsigned SVGA_H_FRONT   = 56;
  localparam int unsigned SVGA_H_SYNC    = 120;
  localparam int unsigned SVGA_H_BACK    = 64;
  localparam int unsigned SVGA_V_VISIBLE = 600;
  localparam int unsigned SVGA_V_FRONT   = 37;
  localparam int unsigned SVGA_V_SYNC    = 6;
  localparam int unsigned SVGA_V_BACK    = 23;
  localparam logic        SVGA_HSYNC_POL = 1'b1;
  localparam logic        SVGA_VSYNC_POL = 1'b1;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int unsigned VGA_H_VISIBLE  = 640;
  localparam int unsigned VGA_H_FRONT    = 16;
  localparam int unsigned VGA_H_SYNC     = 96;
  localparam int unsigned VGA_H_BACK     = 48;
  localparam int unsigned VGA_V_VISIBLE  = 480;
  localparam int unsigned VGA_V_FRONT    = 10;
  localparam int unsigned VGA_V_SYNC     = 2;
  localparam int unsigned VGA_V_BACK     = 33;
  localparam logic        VGA_HSYNC_POL  = 1'b0;
  localparam logic        VGA_VSYNC_POL  = 1'b0;

  // Request-timeline flags carried alongside the framebuffer latency
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } align_t;

  localparam int unsigned ALIGN_W = $bits(align_t);

  // Total period of one axis in pixels or lines
  function automatic int unsigned timing_total(input int unsigned vis,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register; DEPTH=0 collapses to wires.
module vga_delay_line #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = vga_clk ^ reset_n;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per pixel clock
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage[i] <= RESET_VALUE;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel requests to a fixed-latency framebuffer,
// returned colour re-aligned with the sync pulses at the pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE_AREA = SVGA_H_VISIBLE,
  parameter int unsigned H_FRONT_PORCH  = SVGA_H_FRONT,
  parameter int unsigned H_SYNC_PULSE   = SVGA_H_SYNC,
  parameter int unsigned H_BACK_PORCH   = SVGA_H_BACK,
  parameter int unsigned V_VISIBLE_AREA = SVGA_V_VISIBLE,
  parameter int unsigned V_FRONT_PORCH  = SVGA_V_FRONT,
  parameter int unsigned V_SYNC_PULSE   = SVGA_V_SYNC,
  parameter int unsigned V_BACK_PORCH   = SVGA_V_BACK,
  parameter logic        HSYNC_POLARITY = SVGA_HSYNC_POL,
  parameter logic        VSYNC_POLARITY = SVGA_VSYNC_POL,
  parameter int unsigned COLOR_BITS     = 4,
  parameter int unsigned PIXEL_LATENCY  = 2
) (
  input  logic                              vga_clk,
  input  logic                              reset_n,
  output logic                              pix_req,
  output logic [$clog2(H_VISIBLE_AREA)-1:0] pix_x,
  output logic [$clog2(V_VISIBLE_AREA)-1:0] pix_y,
  input  logic [COLOR_BITS-1:0]             pix_r,
  input  logic [COLOR_BITS-1:0]             pix_g,
  input  logic [COLOR_BITS-1:0]             pix_b,
  output logic [COLOR_BITS-1:0]             vga_r,
  output logic [COLOR_BITS-1:0]             vga_g,
  output logic [COLOR_BITS-1:0]             vga_b,
  output logic                              vga_hs,
  output logic                              vga_vs,
  output logic                              frame_start,
  output logic                              line_start
);

  localparam int unsigned H_TOTAL = timing_total(H_VISIBLE_AREA, H_FRONT_PORCH,
                                                 H_SYNC_PULSE, H_BACK_PORCH);
  localparam int unsigned V_TOTAL = timing_total(V_VISIBLE_AREA, V_FRONT_PORCH,
                                                 V_SYNC_PULSE, V_BACK_PORCH);
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned X_W     = $clog2(H_VISIBLE_AREA);
  localparam int unsigned Y_W     = $clog2(V_VISIBLE_AREA);
  localparam int unsigned H_SYNC_START = H_VISIBLE_AREA + H_FRONT_PORCH;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE;
  localparam int unsigned V_SYNC_START = V_VISIBLE_AREA + V_FRONT_PORCH;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE;

  logic [HC_W-1:0] h_cnt, h_nxt;
  logic [VC_W-1:0] v_cnt, v_nxt;
  align_t          req_bits;
  align_t          dly_bits;

  // Raster position registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Next raster position: h wraps every line, v advances on each h wrap
  always_comb begin
    h_nxt = h_cnt + HC_W'(1);
    v_nxt = v_cnt;
    if (h_cnt == HC_W'(H_TOTAL - 1)) begin
      h_nxt = '0;
      if (v_cnt == VC_W'(V_TOTAL - 1)) v_nxt = '0;
      else                             v_nxt = v_cnt + VC_W'(1);
    end
  end

  // Visible/sync decode on the request timeline (sync in positive sense)
  always_comb begin
    req_bits        = '0;
    req_bits.active = (h_cnt < HC_W'(H_VISIBLE_AREA)) &&
                      (v_cnt < VC_W'(V_VISIBLE_AREA));
    req_bits.hsync  = (h_cnt >= HC_W'(H_SYNC_START)) &&
                      ({1'b0, h_cnt} < (HC_W+1)'(H_SYNC_END));
    req_bits.vsync  = (v_cnt >= VC_W'(V_SYNC_START)) &&
                      ({1'b0, v_cnt} < (VC_W+1)'(V_SYNC_END));
  end

  assign pix_req     = reset_n & req_bits.active;
  assign pix_x       = X_W'(h_cnt);
  assign pix_y       = Y_W'(v_cnt);
  assign frame_start = reset_n & (h_cnt == '0) & (v_cnt == '0);
  assign line_start  = reset_n & (h_cnt == '0);

  vga_delay_line #(
    .WIDTH       (ALIGN_W),
    .DEPTH       (PIXEL_LATENCY),
    .RESET_VALUE (ALIGN_W'(0))
  ) u_align (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .din     (req_bits),
    .dout    (dly_bits)
  );

  // Pin register: colour only in visible pixels, sync mapped to polarity
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= ~HSYNC_POLARITY;
      vga_vs <= ~VSYNC_POLARITY;
    end else begin
      vga_r  <= dly_bits.active ? pix_r : '0;
      vga_g  <= dly_bits.active ? pix_g : '0;
      vga_b  <= dly_bits.active ? pix_b : '0;
      vga_hs <= dly_bits.hsync ? HSYNC_POLARITY : ~HSYNC_POLARITY;
      vga_vs <= dly_bits.vsync ? VSYNC_POLARITY : ~VSYNC_POLARITY;
    end
  end

endmodule
